// File: rtl/hack_data_mem.sv
// hack_data_mem
// Responder side of the Hack CPU data-memory bus. Serves RAM, screen and
// keyboard reads combinationally in the cycle of the access. Screen writes
// are stored locally and also queued in a small FIFO that forwards them to
// the display. The CPU can never stall, so the FIFO absorbs display
// back-pressure. A screen write that finds the FIFO full is lost to the
// display only; the local copy is always updated.
//
// Ports
//   clk           system clock
//   rst           synchronous reset, active-low
//   addressM      CPU data address
//   writeM        CPU write strobe for this cycle
//   outM          CPU write data
//   inM           read data for addressM (combinational)
//   kbd_code      scan code from the keyboard front end (0 = key released)
//   kbd_valid     one-cycle strobe: kbd_code is new
//   scr_addr      screen word offset of the FIFO head
//   scr_data      data of the FIFO head
//   scr_valid     FIFO not empty
//   scr_ready     display accepts the head entry
//   scr_overflow  sticky: a screen write was dropped from the FIFO

module hack_data_mem #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 15,
  parameter int SCREEN_BASE = 16384,
  parameter int KBD_ADDR    = 24576,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addressM,
  input  logic              writeM,
  input  logic [DATA_W-1:0] outM,
  output logic [DATA_W-1:0] inM,
  input  logic [DATA_W-1:0] kbd_code,
  input  logic              kbd_valid,
  output logic [12:0]       scr_addr,
  output logic [DATA_W-1:0] scr_data,
  output logic              scr_valid,
  input  logic              scr_ready,
  output logic              scr_overflow
);

  localparam int SCR_AW = 13;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [ADDR_W-1:0] SCR_BASE_A = ADDR_W'(SCREEN_BASE);
  localparam logic [ADDR_W-1:0] KBD_A      = ADDR_W'(KBD_ADDR);
  localparam logic [PTR_W:0]    FULL_CNT   = (PTR_W+1)'(FIFO_DEPTH);

  // RAM and screen share one array; the screen occupies its upper part.
  logic [DATA_W-1:0] mem [0:KBD_ADDR-1];

  logic [DATA_W-1:0] kbd_reg;

  logic [SCR_AW-1:0] fifo_addr [0:FIFO_DEPTH-1];
  logic [DATA_W-1:0] fifo_data [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;

  logic              in_ram;
  logic              in_scr;
  logic              in_kbd;
  logic [SCR_AW-1:0] scr_off;
  logic              fifo_full;
  logic              push_req;
  logic              push;
  logic              pop;

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  assign in_ram  = (addressM < SCR_BASE_A);
  assign in_scr  = (addressM >= SCR_BASE_A) && (addressM < KBD_A);
  assign in_kbd  = (addressM == KBD_A);
  assign scr_off = SCR_AW'(addressM - SCR_BASE_A);

  // ---------------------------------------------------------------------
  // Read path: zero latency; a write in this cycle is seen next cycle
  // ---------------------------------------------------------------------
  always_comb begin
    inM = '0;
    if (in_ram || in_scr) begin
      inM = mem[addressM];
    end else if (in_kbd) begin
      inM = kbd_reg;
    end
  end

  // ---------------------------------------------------------------------
  // Storage array: never cleared, writes blocked during reset
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst && writeM && (in_ram || in_scr)) begin
      mem[addressM] <= outM;
    end
  end

  // ---------------------------------------------------------------------
  // Keyboard register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      kbd_reg <= '0;
    end else if (kbd_valid) begin
      kbd_reg <= kbd_code;
    end
  end

  // ---------------------------------------------------------------------
  // Screen write FIFO
  // ---------------------------------------------------------------------
  assign fifo_full = (count == FULL_CNT);
  assign scr_valid = (count != '0);
  assign pop       = scr_valid && scr_ready;
  assign push_req  = writeM && in_scr;
  // When full, a same-cycle pop frees the head slot, which is also the
  // slot wr_ptr points at, so the new entry can take it.
  assign push      = push_req && (!fifo_full || pop);

  assign scr_addr  = scr_valid ? fifo_addr[rd_ptr] : '0;
  assign scr_data  = scr_valid ? fifo_data[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst && push) begin
      fifo_addr[wr_ptr] <= scr_off;
      fifo_data[wr_ptr] <= outM;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      scr_overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (push_req && !push) begin
        scr_overflow <= 1'b1;
      end
    end
  end

endmodule
